test_controller: RTL

TEST_CONTROLLER -- requirements
Module: test_controller

---
 rtl/test_ctrl_pkg.sv | 24 ++
 rtl/resp_serializer.sv | 78 +++++++
 rtl/test_controller.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/test_ctrl_pkg.sv
// Shared state encoding and protocol byte values for the test controller
// and its response serializer.
package test_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GET_CHAN,
        ST_RUN,
        ST_SEND
    } ctrl_state_t;

    localparam logic [7:0] CMD_START   = 8'h53;  // "S"
    localparam logic [7:0] CMD_ABORT   = 8'h41;  // "A"
    localparam logic [7:0] RSP_RESULT  = 8'h52;  // "R"
    localparam logic [7:0] RSP_TIMEOUT = 8'h54;  // "T"
    localparam logic [7:0] RSP_ABORT   = 8'h41;  // "A"
    localparam logic [7:0] RSP_ERROR   = 8'h45;  // "E"

    // Result frame length: header + channel + score bytes.
    function automatic logic [7:0] result_len(input int unsigned score_bytes);
        return 8'(score_bytes + 2);
    endfunction

endpackage

// File: rtl/resp_serializer.sv
// Latches one response frame (header, channel, score LSB first) and emits it
// byte by byte, never on consecutive cycles and only when the UART is ready.
module resp_serializer
    import test_ctrl_pkg::*;
#(
    parameter int unsigned SCORE_BYTES = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load,
    input  logic [7:0]               len,
    input  logic [7:0]               header,
    input  logic [7:0]               chan,
    input  logic [SCORE_BYTES*8-1:0] score,
    input  logic                     uart_ready,
    output logic                     tx_valid,
    output logic [7:0]               tx_data,
    output logic                     frame_done
);

    logic                     active;
    logic [7:0]               idx;
    logic [7:0]               len_q;
    logic [7:0]               hdr_q;
    logic [7:0]               chan_q;
    logic [SCORE_BYTES*8-1:0] score_q;
    logic [7:0]               cur_byte;

    always_comb begin
        cur_byte = '0;
        if (idx == 8'd0) begin
            cur_byte = hdr_q;
        end else if (idx == 8'd1) begin
            cur_byte = chan_q;
        end else begin
            for (int unsigned b = 0; b < SCORE_BYTES; b++) begin
                if (idx == 8'(b + 2)) cur_byte = score_q[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            active     <= 1'b0;
            idx        <= '0;
            len_q      <= '0;
            hdr_q      <= '0;
            chan_q     <= '0;
            score_q    <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            frame_done <= 1'b0;
            if (load) begin
                active  <= 1'b1;
                idx     <= '0;
                len_q   <= len;
                hdr_q   <= header;
                chan_q  <= chan;
                score_q <= score;
            end else if (active && uart_ready && !tx_valid) begin
                tx_valid <= 1'b1;
                tx_data  <= cur_byte;
                if (idx == len_q - 8'd1) begin
                    active     <= 1'b0;
                    idx        <= '0;
                    frame_done <= 1'b1;
                end else begin
                    idx <= idx + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/test_controller.sv
// UART-driven controller that starts one tester channel, waits for done,
// abort or timeout, and reports the outcome as a short response frame.
module test_controller
    import test_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CHAN    = 4,
    parameter int unsigned SCORE_BYTES = 4,
    parameter int unsigned TIMEOUT     = 1000000
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              uart_ready,
    input  logic                              rx_valid,
    input  logic [7:0]                        rx_data,
    output logic                              tx_valid,
    output logic [7:0]                        tx_data,
    output logic [NUM_CHAN-1:0]               test_start,
    output logic [NUM_CHAN-1:0]               test_abort,
    input  logic [NUM_CHAN-1:0]               test_done,
    input  logic [NUM_CHAN*SCORE_BYTES*8-1:0] test_score,
    output logic                              busy
);

    localparam int unsigned SW    = SCORE_BYTES * 8;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    ctrl_state_t       state;
    logic [7:0]        chan_q;
    logic [SW-1:0]     score_q;
    logic [7:0]        hdr_q;
    logic [7:0]        len_q;
    logic              load_q;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              frame_done;

    logic [NUM_CHAN-1:0] rx_onehot;
    logic [NUM_CHAN-1:0] sel_onehot;
    logic                done_sel;
    logic [SW-1:0]       score_sel;

    always_comb begin
        rx_onehot  = '0;
        sel_onehot = '0;
        done_sel   = 1'b0;
        score_sel  = '0;
        for (int unsigned c = 0; c < NUM_CHAN; c++) begin
            rx_onehot[c] = (rx_data == 8'(c));
            if (chan_q == 8'(c)) begin
                sel_onehot[c] = 1'b1;
                done_sel      = test_done[c];
                score_sel     = test_score[c*SW +: SW];
            end
        end
    end

    // Saturating count; the abort fires on the edge the counter reaches TIMEOUT.
    assign count_next = (count == TO_VAL) ? count : count + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            chan_q     <= '0;
            score_q    <= '0;
            hdr_q      <= '0;
            len_q      <= '0;
            load_q     <= 1'b0;
            count      <= '0;
            test_start <= '0;
            test_abort <= '0;
            busy       <= 1'b0;
        end else begin
            test_start <= '0;
            test_abort <= '0;
            load_q     <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        busy <= 1'b1;
                        if (rx_data == CMD_START) begin
                            state <= ST_GET_CHAN;
                        end else begin
                            hdr_q  <= RSP_ERROR;
                            len_q  <= 8'd1;
                            load_q <= 1'b1;
                            state  <= ST_SEND;
                        end
                    end
                end
                ST_GET_CHAN: begin
                    if (rx_valid) begin
                        if (rx_data < 8'(NUM_CHAN)) begin
                            chan_q     <= rx_data;
                            test_start <= rx_onehot;
                            count      <= '0;
                            state      <= ST_RUN;
                        end else begin
                            hdr_q  <= RSP_ERROR;
                            len_q  <= 8'd1;
                            load_q <= 1'b1;
                            state  <= ST_SEND;
                        end
                    end
                end
                ST_RUN: begin
                    // Priority: done, then abort command, then timeout.
                    if (done_sel) begin
                        score_q <= score_sel;
                        hdr_q   <= RSP_RESULT;
                        len_q   <= result_len(SCORE_BYTES);
                        load_q  <= 1'b1;
                        state   <= ST_SEND;
                    end else if (rx_valid && rx_data == CMD_ABORT) begin
                        test_abort <= sel_onehot;
                        hdr_q      <= RSP_ABORT;
                        len_q      <= 8'd2;
                        load_q     <= 1'b1;
                        state      <= ST_SEND;
                    end else if (count_next == TO_VAL) begin
                        count      <= count_next;
                        test_abort <= sel_onehot;
                        hdr_q      <= RSP_TIMEOUT;
                        len_q      <= 8'd2;
                        load_q     <= 1'b1;
                        state      <= ST_SEND;
                    end else begin
                        count <= count_next;
                    end
                end
                ST_SEND: begin
                    if (frame_done) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    resp_serializer #(
        .SCORE_BYTES(SCORE_BYTES)
    ) u_ser (
        .clock      (clock),
        .reset      (reset),
        .load       (load_q),
        .len        (len_q),
        .header     (hdr_q),
        .chan       (chan_q),
        .score      (score_q),
        .uart_ready (uart_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .frame_done (frame_done)
    );

endmodule
